bottom_calc_arbiter: RTL

Shares the single hard-drop bottom finder (the 20-step row scanner driven by cal_bottom_en / finish_cal_bottom) between two requesters: the hard-drop path (space key) and the ghost-piece preview path.
- Latches the requester's piece context (block, status, pos_x) and holds it stable on the finder inputs for the whole scan.
- Issues the one-cycle start pulse and routes the returned bottom_y to the winner.
- Hard drop has fixed priority. The ghost result is discarded if the piece moved during its scan.

---
 rtl/bottom_calc_arbiter_pkg.sv | 24 ++
 rtl/bottom_calc_arbiter_if.sv | 46 ++++
 rtl/bottom_calc_arbiter_watchdog.sv | 30 +++
 rtl/bottom_calc_arbiter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/bottom_calc_arbiter_pkg.sv
// Shared types and encodings for the bottom-finder arbiter.
// States, owner codes and piece-context bundle.
package bottom_arb_pkg;

  localparam int BOARD_ROWS = 20;
  localparam int POS_X_W    = 5;
  localparam int POS_Y_W    = 5;
  localparam int BLOCK_W    = 3;
  localparam int STATUS_W   = 2;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LAUNCH = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  localparam logic OWN_DROP  = 1'b0;
  localparam logic OWN_GHOST = 1'b1;

  typedef struct packed {
    logic [BLOCK_W-1:0]  block;
    logic [STATUS_W-1:0] status;
    logic [POS_X_W-1:0]  pos_x;
  } piece_ctx_t;

endpackage

// File: rtl/bottom_calc_arbiter_if.sv
// Requester and finder signal bundle for bottom_calc_arbiter.
// slave = arbiter side, master = environment side.
interface bottom_calc_arbiter_if;
  import bottom_arb_pkg::*;

  logic                drop_req;
  logic [BLOCK_W-1:0]  drop_block;
  logic [STATUS_W-1:0] drop_status;
  logic [POS_X_W-1:0]  drop_pos_x;
  logic                drop_ack;
  logic [POS_Y_W-1:0]  drop_y;
  logic                drop_err;

  logic                ghost_dirty;
  logic [BLOCK_W-1:0]  cur_block;
  logic [STATUS_W-1:0] cur_status;
  logic [POS_X_W-1:0]  cur_pos_x;
  logic                ghost_valid;
  logic [POS_Y_W-1:0]  ghost_y;

  logic [BLOCK_W-1:0]  calc_block;
  logic [STATUS_W-1:0] calc_status;
  logic [POS_X_W-1:0]  calc_pos_x;
  logic                cal_bottom_en;
  logic                finish_cal_bottom;
  logic [POS_Y_W-1:0]  bottom_y;

  modport slave (
    input  drop_req, drop_block, drop_status, drop_pos_x,
    output drop_ack, drop_y, drop_err,
    input  ghost_dirty, cur_block, cur_status, cur_pos_x,
    output ghost_valid, ghost_y,
    output calc_block, calc_status, calc_pos_x, cal_bottom_en,
    input  finish_cal_bottom, bottom_y
  );

  modport master (
    output drop_req, drop_block, drop_status, drop_pos_x,
    input  drop_ack, drop_y, drop_err,
    output ghost_dirty, cur_block, cur_status, cur_pos_x,
    input  ghost_valid, ghost_y,
    input  calc_block, calc_status, calc_pos_x, cal_bottom_en,
    output finish_cal_bottom, bottom_y
  );

endinterface

// File: rtl/bottom_calc_arbiter_watchdog.sv
// WAIT-state cycle counter; fire marks the last allowed WAIT cycle.
// Only instantiated when BOTTOM_ARB_WATCHDOG_EN is defined.
module bottom_arb_watchdog #(
  parameter int TIMEOUT_CYC = 31
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic fire
);

  logic [4:0] cnt_q, cnt_d;

  assign fire = en && (cnt_q == 5'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (en && !fire)
      cnt_d = cnt_q + 5'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/bottom_calc_arbiter.sv
// Shares one bottom finder between hard drop and ghost preview.
// Optional WAIT watchdog: define BOTTOM_ARB_WATCHDOG_EN.
module bottom_calc_arbiter
  import bottom_arb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 31
) (
  input logic clk,
  input logic rst,
  bottom_calc_arbiter_if.slave bus
);

  logic [1:0]         state_q, state_d;
  logic               owner_q, owner_d;
  logic               pend_q, pend_d;
  logic               stale_q, stale_d;
  piece_ctx_t         calc_q, calc_d;
  logic               en_q, en_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [POS_Y_W-1:0] dy_q, dy_d;
  logic               gv_q, gv_d;
  logic [POS_Y_W-1:0] gy_q, gy_d;
  logic               wd_fire;

  if (TIMEOUT_CYC < 24 || TIMEOUT_CYC > 31) begin : g_bad_to
    $error("TIMEOUT_CYC must be in 24..31");
  end

`ifdef BOTTOM_ARB_WATCHDOG_EN
  bottom_arb_watchdog #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wd (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q == ST_LAUNCH),
    .en   (state_q == ST_WAIT),
    .fire (wd_fire)
  );
`else
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    pend_d  = pend_q | bus.ghost_dirty;
    stale_d = stale_q;
    calc_d  = calc_q;
    en_d    = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    dy_d    = dy_q;
    gv_d    = gv_q & ~bus.ghost_dirty;
    gy_d    = gy_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.drop_req) begin
          calc_d  = '{bus.drop_block, bus.drop_status,
                      bus.drop_pos_x};
          owner_d = OWN_DROP;
          en_d    = 1'b1;
          state_d = ST_LAUNCH;
        end else if (pend_q) begin
          calc_d  = '{bus.cur_block, bus.cur_status,
                      bus.cur_pos_x};
          pend_d  = bus.ghost_dirty;
          stale_d = 1'b0;
          owner_d = OWN_GHOST;
          en_d    = 1'b1;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (owner_q == OWN_GHOST && bus.ghost_dirty)
          stale_d = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (owner_q == OWN_GHOST && bus.ghost_dirty)
          stale_d = 1'b1;
        if (bus.finish_cal_bottom) begin
          state_d = ST_IDLE;
          if (owner_q == OWN_DROP) begin
            ack_d = 1'b1;
            dy_d  = bus.bottom_y;
            gv_d  = 1'b0;
          end else if (!stale_q && !bus.ghost_dirty) begin
            gv_d = 1'b1;
            gy_d = bus.bottom_y;
          end
        end else if (wd_fire) begin
          // finder is stuck: release the owner so play continues
          state_d = ST_IDLE;
          if (owner_q == OWN_DROP) begin
            ack_d = 1'b1;
            err_d = 1'b1;
            dy_d  = '0;
          end else begin
            gv_d   = 1'b0;
            pend_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_DROP;
      pend_q  <= 1'b0;
      stale_q <= 1'b0;
      calc_q  <= '0;
      en_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dy_q    <= '0;
      gv_q    <= 1'b0;
      gy_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      pend_q  <= pend_d;
      stale_q <= stale_d;
      calc_q  <= calc_d;
      en_q    <= en_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dy_q    <= dy_d;
      gv_q    <= gv_d;
      gy_q    <= gy_d;
    end
  end

  assign bus.calc_block    = calc_q.block;
  assign bus.calc_status   = calc_q.status;
  assign bus.calc_pos_x    = calc_q.pos_x;
  assign bus.cal_bottom_en = en_q;
  assign bus.drop_ack      = ack_q;
  assign bus.drop_y        = dy_q;
  assign bus.drop_err      = err_q;
  assign bus.ghost_valid   = gv_q;
  assign bus.ghost_y       = gy_q;

endmodule
